// File: rtl/gcd_display_if.sv
// Handshake bundle between the upstream GCD calculator and gcd_display.
// master: drives gcd_ready/gcd_result, reads busy; slave: the display side.
`timescale 1ns/1ps
interface gcd_display_if;
    logic       gcd_ready;
    logic [7:0] gcd_result;
    logic       busy;

    modport master (
        output gcd_ready,
        output gcd_result,
        input  busy
    );

    modport slave (
        input  gcd_ready,
        input  gcd_result,
        output busy
    );
endinterface

// File: rtl/gcd_display.sv
// Captures an 8-bit GCD result, converts it to BCD by shift-add-3 and scans
// it onto a 3-digit multiplexed 7-segment display with leading-zero blanking.
// Ports: clock, reset (async, active low), gcd (slave: gcd_ready,
// gcd_result in; busy out), bcd {h,t,o}, anode and segments (active low).
`timescale 1ns/1ps
module gcd_display #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    gcd_display_if.slave gcd,
    output logic [11:0] bcd,
    output logic [3:0]  anode,
    output logic [6:0]  segments
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam logic [19:0] REF_MAX = 20'(REFRESH_CYCLES - 1);

    state_t      state;
    logic        busy_q;
    logic        shown;
    logic [7:0]  bin;
    logic [11:0] work;
    logic [2:0]  iter;
    logic [19:0] ref_cnt;
    logic [1:0]  sel;

    logic [11:0] adj;
    logic [19:0] shift_nxt;

    assign gcd.busy = busy_q;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // One shift-add-3 step: correct nibbles first, then shift {bcd,bin}.
    always_comb begin
        adj       = {add3(work[11:8]), add3(work[7:4]), add3(work[3:0])};
        shift_nxt = {adj, bin} << 1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            shown   <= 1'b0;
            bin     <= '0;
            work    <= '0;
            iter    <= '0;
            bcd     <= '0;
            ref_cnt <= '0;
            sel     <= '0;
        end else begin
            if (ref_cnt == REF_MAX) begin
                ref_cnt <= '0;
                sel     <= sel + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 20'd1;
            end

            unique case (state)
                IDLE, SHOW: begin
                    if (gcd.gcd_ready) begin
                        bin    <= gcd.gcd_result;
                        work   <= '0;
                        iter   <= '0;
                        busy_q <= 1'b1;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    {work, bin} <= shift_nxt;
                    iter        <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        bcd    <= shift_nxt[19:8];
                        busy_q <= 1'b0;
                        shown  <= 1'b1;
                        state  <= SHOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display decode uses only registered state; shown stays set while a
    // later conversion runs so the previous value keeps being displayed.
    logic [3:0] hun, ten, one;
    logic       hun_blank, ten_blank;

    always_comb begin
        hun       = bcd[11:8];
        ten       = bcd[7:4];
        one       = bcd[3:0];
        hun_blank = (hun == 4'd0);
        ten_blank = hun_blank && (ten == 4'd0);
        anode     = 4'b1111;
        segments  = 7'b1111111;
        if (shown) begin
            unique case (1'b1)
                (sel == 2'd0): begin
                    anode    = 4'b1110;
                    segments = seg7(one);
                end
                (sel == 2'd1): begin
                    if (!ten_blank) begin
                        anode    = 4'b1101;
                        segments = seg7(ten);
                    end
                end
                (sel == 2'd2): begin
                    if (!hun_blank) begin
                        anode    = 4'b1011;
                        segments = seg7(hun);
                    end
                end
                default: begin
                    anode    = 4'b1111;
                    segments = 7'b1111111;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_display.sv
// Directed bench for gcd_display: conversion latency, BCD values, ignored
// strobes, abort by reset and the multiplexed scan with blanking.
`timescale 1ns/1ps
module tb_gcd_display;

    logic        clock;
    logic        reset;
    logic [11:0] bcd;
    logic [3:0]  anode;
    logic [6:0]  segments;
    int          n_cmp;
    int          n_bad;

    gcd_display_if gif();

    gcd_display #(.REFRESH_CYCLES(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .gcd      (gif.slave),
        .bcd      (bcd),
        .anode    (anode),
        .segments (segments)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Strobe one value; returns at the negedge after the capture edge.
    task automatic pulse(input logic [7:0] v);
        @(negedge clock);
        gif.gcd_ready  = 1'b1;
        gif.gcd_result = v;
        @(negedge clock);
        gif.gcd_ready  = 1'b0;
    endtask

    // Count negedge samples with busy high, starting at the current one.
    task automatic wait_busy(input string tag, input int exp);
        int cnt;
        cnt = 0;
        while (gif.busy && cnt < 20) begin
            cnt++;
            @(negedge clock);
        end
        chk(tag, cnt, exp);
    endtask

    task automatic scan(input string tag,
                        input logic [3:0] a0, input logic [6:0] s0,
                        input logic [3:0] a1, input logic [6:0] s1,
                        input logic [3:0] a2, input logic [6:0] s2);
        logic [3:0] ea[4];
        logic [6:0] es[4];
        int t;
        ea[0] = a0; es[0] = s0;
        ea[1] = a1; es[1] = s1;
        ea[2] = a2; es[2] = s2;
        ea[3] = 4'b1111; es[3] = 7'b1111111;
        t = 0;
        while (anode == 4'b1110 && t < 40) begin
            t++;
            @(negedge clock);
        end
        while (anode != 4'b1110 && t < 40) begin
            t++;
            @(negedge clock);
        end
        chk({tag, "_sync"}, 32'(t < 40), 32'd1);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++)
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("%s_an_s%0d", tag, s), 32'(anode), 32'(ea[s]));
                    chk($sformatf("%s_sg_s%0d", tag, s), 32'(segments), 32'(es[s]));
                    @(negedge clock);
                end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        gif.gcd_ready  = 1'b0;
        gif.gcd_result = 8'd0;
        #3;
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_seg", 32'(segments), 32'h7F);
        chk("rst_busy", 32'(gif.busy), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h000);
        @(negedge clock);
        reset = 1'b1;

        // 255: blank during first conversion, 8 busy cycles
        pulse(8'd255);
        chk("cvt_blank", 32'(anode), 32'hF);
        chk("cvt_bcd0", 32'(bcd), 32'h000);
        wait_busy("busy255", 8);
        chk("bcd255", 32'(bcd), 32'h255);
        scan("s255", 4'b1110, 7'b0100100, 4'b1101, 7'b0100100,
             4'b1011, 7'b0010010);

        // 7: old value held while converting; strobe on completion edge
        pulse(8'd7);
        chk("hold255", 32'(bcd), 32'h255);
        repeat (7) @(negedge clock);
        gif.gcd_ready  = 1'b1;
        gif.gcd_result = 8'd200;
        @(negedge clock);
        gif.gcd_ready  = 1'b0;
        chk("done_busy", 32'(gif.busy), 32'd0);
        chk("bcd7", 32'(bcd), 32'h007);
        @(negedge clock);
        chk("no_restart", 32'(gif.busy), 32'd0);
        scan("s7", 4'b1110, 7'b0001111, 4'b1111, 7'b1111111,
             4'b1111, 7'b1111111);

        // 36 with a 99 strobe on the 3rd iteration edge
        pulse(8'd36);
        repeat (2) @(negedge clock);
        gif.gcd_ready  = 1'b1;
        gif.gcd_result = 8'd99;
        @(negedge clock);
        gif.gcd_ready  = 1'b0;
        wait_busy("busy36", 5);
        chk("bcd36", 32'(bcd), 32'h036);
        scan("s36", 4'b1110, 7'b0100000, 4'b1101, 7'b0000110,
             4'b1111, 7'b1111111);

        // abort at iteration 4, then 100
        pulse(8'd55);
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort_an", 32'(anode), 32'hF);
        chk("abort_seg", 32'(segments), 32'h7F);
        chk("abort_busy", 32'(gif.busy), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'h000);
        @(negedge clock);
        reset = 1'b1;
        pulse(8'd100);
        wait_busy("busy100", 8);
        chk("bcd100", 32'(bcd), 32'h100);
        scan("s100", 4'b1110, 7'b0000001, 4'b1101, 7'b0000001,
             4'b1011, 7'b1001111);

        // 123 refresh sequence, then reset mid-scan
        pulse(8'd123);
        wait_busy("busy123", 8);
        chk("bcd123", 32'(bcd), 32'h123);
        scan("s123", 4'b1110, 7'b0000110, 4'b1101, 7'b0010010,
             4'b1011, 7'b1001111);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("mrst_an", 32'(anode), 32'hF);
        chk("mrst_seg", 32'(segments), 32'h7F);
        chk("mrst_busy", 32'(gif.busy), 32'd0);
        chk("mrst_bcd", 32'(bcd), 32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_display.md
GCD_DISPLAY -- requirements
Module: gcd_display

Interface
REQ-001 Parameter REFRESH_CYCLES, default 100000, sets the clock cycles each digit slot is displayed; legal range 2 to 2^20.
REQ-002 Port clock, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-low reset; 0 SHALL clear all state immediately, independent of clock.
REQ-004 Port gcd_ready, input, 1, single-cycle strobe marking gcd_result valid; driven by the GCD calculator upstream.
REQ-005 Port gcd_result, input, 8, unsigned binary result; sampled only in the cycle gcd_ready=1.
REQ-006 Port busy, output, 1, high while a binary-to-BCD conversion is in progress.
REQ-007 Port bcd, output, 12, {hundreds, tens, ones} BCD of the last completed conversion.
REQ-008 Port anode, output, 4, active-low digit enables; bit 0 = ones, bit 1 = tens, bit 2 = hundreds, bit 3 = unused.
REQ-009 Port segments, output, 7, active-low cathodes; bit order {a,b,c,d,e,f,g} from bit 6 down to bit 0.

Function
REQ-010 The block SHALL implement the FSM states IDLE, CONVERT and SHOW.
REQ-011 In IDLE, no value has been captured since reset; anode SHALL be 4'b1111 and segments SHALL be 7'b1111111.
REQ-012 In IDLE or SHOW, gcd_ready=1 at an edge SHALL load gcd_result into the shift register, clear the working BCD, and enter CONVERT.
REQ-013 CONVERT SHALL run exactly 8 iterations, one per clock (shift-add-3).
REQ-014 Each iteration SHALL first add 3 to every working BCD nibble that is >= 5, then shift {BCD, binary} left by 1.
REQ-015 On the 8th iteration edge, the block SHALL load bcd from the working register and enter SHOW.
REQ-016 busy SHALL be 1 for exactly 8 cycles, from the capture edge to the 8th iteration edge; latency from the capture edge to new bcd is 8 clocks.
REQ-017 During CONVERT, bcd, anode and segments SHALL keep showing the previous value (blank if coming from IDLE).
REQ-018 gcd_ready in CONVERT SHALL be ignored; nothing is queued.
REQ-019 gcd_ready on the same edge that completes a conversion SHALL also be ignored.
REQ-020 A refresh counter SHALL count 0 to REFRESH_CYCLES-1 and wrap in all states.
REQ-021 At each wrap, a 2-bit digit select SHALL advance 0->1->2->3->0.
REQ-022 In SHOW, slot 0 drives anode 4'b1110 with the ones digit, slot 1 drives 4'b1101 with tens, slot 2 drives 4'b1011 with hundreds, and slot 3 drives 4'b1111 (blank).
REQ-023 Leading zeros SHALL be blanked: hundreds when it is 0, and tens when hundreds and tens are both 0; the ones digit SHALL always be shown.
REQ-024 A blanked slot SHALL drive anode 4'b1111 and segments 7'b1111111.
REQ-025 Segment codes SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-026 anode and segments SHALL be a combinational decode of registered state only, never of gcd_ready or gcd_result directly.

Reset
REQ-027 On reset=0, the block SHALL set: state IDLE, busy 0, bcd 12'h000, refresh counter 0, digit select 0, anode 4'b1111, segments 7'b1111111.
REQ-028 Reset during CONVERT SHALL abort the conversion with no partial bcd update; the block SHALL return to IDLE (blank display).
REQ-029 After reset releases, the first gcd_ready SHALL be accepted on the first rising edge.

Verification
REQ-030 Scenario reset: hold reset=0 mid-scan -> anode=1111, segments=1111111, busy=0, bcd=000, with no clock edge required.
REQ-031 Scenario max value: gcd_ready pulse with gcd_result=255 -> busy high 8 cycles, then bcd=12'h255; scan shows 5, 5, 2.
REQ-032 Scenario small value: gcd_result=7 -> bcd=12'h007; anode bits 1 and 2 never low; ones slot segments=0001111.
REQ-033 Scenario ignored strobe: gcd_result=36, then gcd_ready with 99 at iteration 3 -> bcd=12'h036, and busy drops after the original 8 cycles.
REQ-034 Scenario abort and restart: reset at iteration 4 -> blank display, bcd=000; then gcd_result=100 -> bcd=12'h100 and the tens slot shows 0 (not blanked).
REQ-035 Scenario refresh: REFRESH_CYCLES=4 with bcd=12'h123 -> anode sequence 1110, 1101, 1011, 1111, each held 4 cycles, repeating.
